// File: rtl/nibble_collector.sv
// Assembles LSB-first serial nibbles into an N-bit result with a ready/valid hold stage.
// Optional XOR frame checksum on res_chk when NIBBLE_COLLECTOR_CHECKSUM_EN is defined.
module nibble_collector #(
   parameter int unsigned N       = 64,
   parameter int unsigned N_WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic [N_WIDTH-1:0] in_nibble,
   input  logic               res_ready,
   input  logic               err_clr,
   output logic               res_valid,
   output logic [N-1:0]       res_data,
   output logic [N_WIDTH-1:0] res_chk,
   output logic               busy,
   output logic               overflow_err,
   output logic [7:0]         frames_done
);

   localparam int unsigned NUM_NIB = N / N_WIDTH;
   localparam int unsigned CNT_W   = $clog2(NUM_NIB) + 1;
   localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(NUM_NIB - 1);

   typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

   state_t           state, state_next;
   logic [CNT_W-1:0] nib_cnt;
   logic             start_frame, store_nib, handshake, ovf_set;

   always_comb begin
      state_next  = state;
      start_frame = 1'b0;
      store_nib   = 1'b0;
      handshake   = 1'b0;
      ovf_set     = 1'b0;
      unique case (state)
         IDLE: begin
            if (in_valid) begin
               start_frame = 1'b1;
               state_next  = COLLECT;
            end
         end
         COLLECT: begin
            if (in_valid) begin
               store_nib = 1'b1;
               if (nib_cnt == LAST_SLOT) state_next = HOLD;
            end
         end
         HOLD: begin
            // A nibble arriving with the handshake opens the next frame; otherwise it is lost.
            if (res_ready) begin
               handshake = 1'b1;
               if (in_valid) begin
                  start_frame = 1'b1;
                  state_next  = COLLECT;
               end else begin
                  state_next = IDLE;
               end
            end else if (in_valid) begin
               ovf_set = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         nib_cnt      <= '0;
         res_data     <= '0;
         overflow_err <= 1'b0;
         frames_done  <= '0;
      end else begin
         state <= state_next;
         if (start_frame) begin
            res_data                <= '0;
            res_data[N_WIDTH-1:0]   <= in_nibble;
            nib_cnt                 <= CNT_W'(1);
         end else if (store_nib) begin
            for (int unsigned i = 0; i < NUM_NIB; i++) begin
               if (nib_cnt == CNT_W'(i)) res_data[i*N_WIDTH +: N_WIDTH] <= in_nibble;
            end
            nib_cnt <= nib_cnt + CNT_W'(1);
         end else if (handshake) begin
            nib_cnt <= '0;
         end
         if (handshake) frames_done <= frames_done + 8'd1;
         if (ovf_set)      overflow_err <= 1'b1;
         else if (err_clr) overflow_err <= 1'b0;
      end
   end

`ifdef NIBBLE_COLLECTOR_CHECKSUM_EN
   logic [N_WIDTH-1:0] chk_acc;

   always_ff @(posedge clk) begin
      if (rst)              chk_acc <= '0;
      else if (start_frame) chk_acc <= in_nibble;
      else if (store_nib)   chk_acc <= chk_acc ^ in_nibble;
   end

   assign res_chk = chk_acc;
`else
   assign res_chk = '0;
`endif

   assign res_valid = (state == HOLD);
   assign busy      = (state == COLLECT);

endmodule

// File: tb/tb_nibble_collector.sv
// Directed self-checking bench for nibble_collector (N=64, N_WIDTH=4).
module tb_nibble_collector;

`ifdef NIBBLE_COLLECTOR_CHECKSUM_EN
   localparam bit CHK_EN = 1'b1;
`else
   localparam bit CHK_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst, in_valid, res_ready, err_clr;
   logic [3:0]  in_nibble;
   logic        res_valid, busy, overflow_err;
   logic [63:0] res_data;
   logic [3:0]  res_chk;
   logic [7:0]  frames_done;

   int compared   = 0;
   int mismatched = 0;
   int cyc;

   nibble_collector #(.N(64), .N_WIDTH(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_nibble(in_nibble),
      .res_ready(res_ready), .err_clr(err_clr), .res_valid(res_valid),
      .res_data(res_data), .res_chk(res_chk), .busy(busy),
      .overflow_err(overflow_err), .frames_done(frames_done)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [3:0] nib);
      in_valid  = 1'b1;
      in_nibble = nib;
      tick();
      in_valid  = 1'b0;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_nibble = '0; res_ready = 1'b0; err_clr = 1'b0;
      tick(); tick();
      rst = 1'b0;
      chk("rst_valid", 64'(res_valid), 64'd0);
      chk("rst_data", res_data, 64'd0);
      chk("rst_chk", 64'(res_chk), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_ovf", 64'(overflow_err), 64'd0);
      chk("rst_frames", 64'(frames_done), 64'd0);

      // Frame A: 1..F,0 back to back
      for (int i = 0; i < 16; i++) begin
         send(4'((i + 1) & 15));
         chk("a_busy", 64'(busy), (i < 15) ? 64'd1 : 64'd0);
         chk("a_valid", 64'(res_valid), (i < 15) ? 64'd0 : 64'd1);
      end
      chk("a_data", res_data, 64'h0FED_CBA9_8765_4321);
      chk("a_chk", 64'(res_chk), 64'd0);
      tick(); tick();
      chk("hold_valid", 64'(res_valid), 64'd1);
      chk("hold_data", res_data, 64'h0FED_CBA9_8765_4321);

      // Overflow while holding, then clear; then set-wins-over-clear
      send(4'hA);
      chk("ovf_set", 64'(overflow_err), 64'd1);
      chk("ovf_data", res_data, 64'h0FED_CBA9_8765_4321);
      chk("ovf_valid", 64'(res_valid), 64'd1);
      err_clr = 1'b1; tick(); err_clr = 1'b0;
      chk("ovf_clr", 64'(overflow_err), 64'd0);
      err_clr = 1'b1; send(4'h3); err_clr = 1'b0;
      chk("ovf_setwins", 64'(overflow_err), 64'd1);
      err_clr = 1'b1; tick(); err_clr = 1'b0;
      chk("ovf_clr2", 64'(overflow_err), 64'd0);

      // Handshake without a new nibble returns to idle
      res_ready = 1'b1; tick(); res_ready = 1'b0;
      chk("hs1_valid", 64'(res_valid), 64'd0);
      chk("hs1_frames", 64'(frames_done), 64'd1);
      chk("hs1_busy", 64'(busy), 64'd0);

      // Gapped frame: 3 idle cycles after nibbles 4 and 9
      cyc = 0;
      for (int i = 0; i < 16; i++) begin
         send(4'((i + 1) & 15));
         cyc++;
         if (i == 3 || i == 8) begin
            for (int g = 0; g < 3; g++) begin
               tick();
               cyc++;
               chk("gap_busy", 64'(busy), 64'd1);
               chk("gap_valid", 64'(res_valid), 64'd0);
            end
         end
      end
      chk("gap_latency", 64'(cyc), 64'd22);
      chk("gap_valid_end", 64'(res_valid), 64'd1);
      chk("gap_data", res_data, 64'h0FED_CBA9_8765_4321);

      // Handshake with simultaneous first nibble of the next frame
      res_ready = 1'b1; send(4'h7); res_ready = 1'b0;
      chk("hsb_frames", 64'(frames_done), 64'd2);
      chk("hsb_busy", 64'(busy), 64'd1);
      chk("hsb_valid", 64'(res_valid), 64'd0);
      chk("hsb_slot0", res_data, 64'h7);
      for (int i = 1; i < 16; i++) send(4'(i));
      chk("b_valid", 64'(res_valid), 64'd1);
      chk("b_data", res_data, 64'hFEDC_BA98_7654_3217);
      chk("b_chk", 64'(res_chk), CHK_EN ? 64'h7 : 64'd0);
      res_ready = 1'b1; tick(); res_ready = 1'b0;
      chk("hs3_frames", 64'(frames_done), 64'd3);

      // Reset mid-frame takes priority over an arriving nibble
      for (int i = 0; i < 8; i++) send(4'h3);
      chk("mid_busy", 64'(busy), 64'd1);
      rst = 1'b1; send(4'hC); rst = 1'b0;
      chk("mrst_data", res_data, 64'd0);
      chk("mrst_busy", 64'(busy), 64'd0);
      chk("mrst_valid", 64'(res_valid), 64'd0);
      chk("mrst_frames", 64'(frames_done), 64'd0);
      chk("mrst_chk", 64'(res_chk), 64'd0);
      for (int i = 0; i < 16; i++) send(4'h5);
      chk("f5_data", res_data, 64'h5555_5555_5555_5555);
      chk("f5_chk", 64'(res_chk), 64'd0);
      res_ready = 1'b1; tick(); res_ready = 1'b0;

      // Fifteen zeros then 9
      for (int i = 0; i < 15; i++) send(4'h0);
      send(4'h9);
      chk("f9_data", res_data, 64'h9000_0000_0000_0000);
      chk("f9_chk", 64'(res_chk), CHK_EN ? 64'h9 : 64'd0);
      res_ready = 1'b1; tick(); res_ready = 1'b0;
      chk("f9_frames", 64'(frames_done), 64'd2);

      // Run to 256 handshakes since reset: counter wraps to 0
      for (int f = 0; f < 254; f++) begin
         for (int i = 0; i < 16; i++) send(4'(f));
         if (f == 253) chk("wrap_pre", 64'(frames_done), 64'd255);
         res_ready = 1'b1; tick(); res_ready = 1'b0;
      end
      chk("wrap_frames", 64'(frames_done), 64'd0);
      chk("wrap_valid", 64'(res_valid), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
